tdm_demux_1x4: RTL and testbench
================================

// Module: tdm_demux_1x4
// PURPOSE
//  Receive end of the 4-channel time-division link. The transmit side serialises
//  four channels with a 2-bit slot select. This block re-distributes the serial
//  beats into four registered parallel outputs. It locks to a frame-sync marker,
//  tracks the slot with an internal counter and presents each complete frame
//  with a one-cycle valid strobe. It sits between the serial link and the
//  per-channel consumers.
// PARAMETERS
//  WIDTH  1  data bits carried per slot (per channel)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  din          in   WIDTH    serial slot data
//  din_valid    in   1        din/sync_in qualify this cycle (gaps allowed)
//  sync_in      in   1        marks the current valid beat as slot 0
//  y            out  4*WIDTH  last complete frame; y[k*WIDTH +: WIDTH] = channel k
//  frame_valid  out  1        1-cycle pulse: y just updated
//  slot         out  2        slot index expected for the next valid beat
//  locked       out  1        1 while in LOCKED state
//  sync_err     out  1        1-cycle pulse: sync_in seen on a beat whose slot != 0
// BEHAVIOUR
//  - Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
//    All outputs are registered.
//  - Reset values: y=0, frame_valid=0, slot=0, locked=0, sync_err=0.
//    Internal shadow[0..3]=0. FSM=HUNT.
//  - A beat is any cycle with din_valid=1. Cycles with din_valid=0 change nothing
//    except clearing the pulse outputs.
//  - FSM HUNT: beats without sync_in are discarded.
//    A beat with sync_in writes shadow[0]=din, sets slot=1 and moves to LOCKED.
//  - FSM LOCKED, beat with sync_in=0: shadow[slot]=din, then slot=slot+1
//    (wraps 3->0).
//  - LOCKED, beat with slot==3: y <= {din,shadow[2],shadow[1],shadow[0]} and
//    frame_valid <= 1, both on the same edge. Latency is 1 edge from the
//    slot-3 sample to y/frame_valid visible.
//  - LOCKED, beat with sync_in=1 and slot==0: normal slot-0 beat. sync_in is
//    optional after lock; slot 0 without sync is accepted.
//  - LOCKED, beat with sync_in=1 and slot!=0 (misalignment):
//    - sync_err pulses and the partial frame is dropped; y is not updated and
//      there is no frame_valid.
//    - The beat is re-taken as slot 0: shadow[0]=din, slot=1. Lock is kept.
//  - frame_valid and sync_err are high for exactly one cycle per event and
//    never assert in the same cycle.
//  - Reset mid-frame: partial frame is lost, y returns to 0, FSM returns to HUNT.
//  - y holds its value between frames and is never partially updated.
// CONFIGURATION
//  - TDM_DEMUX_PARITY_EN defined:
//    - Extra ports din_par (in, 1) and par_err (out, 1, reset 0).
//    - Every accepted beat is checked for even parity: ^{din,din_par} must be 0.
//    - Any mismatch within a frame marks the frame bad. At slot 3, a bad frame
//      pulses par_err instead of frame_valid, and y is unchanged.
//    - The bad mark clears at frame end, on re-alignment and on reset.
//    - Beats discarded in HUNT are not checked.
//  - TDM_DEMUX_PARITY_EN undefined: no din_par/par_err ports and no parity logic.
// TESTING
//  1. Reset, then a frame with WIDTH=1: beats 1(sync),0,1,1 on consecutive
//     cycles -> after the 4th edge y=4'b1101, frame_valid=1 for 1 cycle,
//     slot=0, locked=1.
//  2. In HUNT, send 3 beats without sync, then a synced frame 0,1,0,0 ->
//     the first 3 are ignored, y=4'b0010, exactly one frame_valid.
//  3. Same frame as test 2 with din_valid=0 gaps of 2 cycles between beats ->
//     same y=4'b0010, frame_valid only after the 4th valid beat.
//  4. Locked: after 2 beats of a frame, a beat with sync_in and din=1, then
//     0,0,1 -> sync_err pulses once, no frame_valid for the partial frame,
//     then y=4'b1001.
//  5. Assert rst_n=0 asynchronously after slot 2 -> all outputs 0 without
//     waiting for clk; after release, beats without sync are ignored.
//  6. (TDM_DEMUX_PARITY_EN) frame with a wrong din_par on slot 1 -> par_err
//     pulses, no frame_valid, y unchanged. The next good frame updates y
//     normally.

Source files
------------

// File: rtl/tdm_demux_1x4_if.sv
// Serial-link side and frame-output side of the 4-slot TDM demux.
// Latency: n/a (signal bundle only).
// Backpressure: none; the link is push-only, gated by din_valid.
interface tdm_demux_1x4_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               sync_in;
  logic [4*WIDTH-1:0] y;
  logic               frame_valid;
  logic [1:0]         slot;
  logic               locked;
  logic               sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic               din_par;
  logic               par_err;

  modport master (output din, din_valid, sync_in, din_par,
                  input  y, frame_valid, slot, locked, sync_err, par_err);
  modport slave  (input  din, din_valid, sync_in, din_par,
                  output y, frame_valid, slot, locked, sync_err, par_err);
`else
  modport master (output din, din_valid, sync_in,
                  input  y, frame_valid, slot, locked, sync_err);
  modport slave  (input  din, din_valid, sync_in,
                  output y, frame_valid, slot, locked, sync_err);
`endif
endinterface

// File: rtl/tdm_demux_1x4.sv
// 4-slot TDM receive demux: locks on sync_in, collects slots 0..3 into y.
// Latency: y/frame_valid visible 1 edge after the slot-3 beat is sampled.
// Backpressure: none; beats qualified by din_valid, idle cycles hold state.
// Optional even-parity check per beat under macro TDM_DEMUX_PARITY_EN.
module tdm_demux_1x4 #(
  parameter int WIDTH = 1
) (
  input logic              clk,
  input logic              rst_n,
  tdm_demux_1x4_if.slave   bus
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [WIDTH-1:0]   sh0_q, sh1_q, sh2_q, sh0_d, sh1_d, sh2_d;
  logic [4*WIDTH-1:0] y_q, y_d;
  logic               fv_q, fv_d;
  logic               se_q, se_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic               bad_q, bad_d;
  logic               pe_q, pe_d;
  logic               mis;
`endif

  // State register: FSM, slot counter, shadow slots and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      y_q     <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      bad_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      y_q     <= y_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
`ifdef TDM_DEMUX_PARITY_EN
      bad_q   <= bad_d;
      pe_q    <= pe_d;
`endif
    end
  end

  // Next-state: hunt for sync, then fill slots; a sync on slot!=0 realigns.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    y_d     = y_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    bad_d   = bad_q;
    pe_d    = 1'b0;
    mis     = ^{bus.din, bus.din_par};
`endif
    if (bus.din_valid) begin
      if (state_q == HUNT) begin
        // Non-sync beats while hunting are dropped unchecked.
        if (bus.sync_in) begin
          sh0_d   = bus.din;
          slot_d  = 2'd1;
          state_d = LOCKED;
`ifdef TDM_DEMUX_PARITY_EN
          bad_d   = mis;
`endif
        end
      end else if (bus.sync_in && (slot_q != 2'd0)) begin
        // Misaligned sync: drop the partial frame, restart at slot 0.
        se_d   = 1'b1;
        sh0_d  = bus.din;
        slot_d = 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
        bad_d  = mis;
`endif
      end else begin
        slot_d = slot_q + 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
        bad_d  = bad_q | mis;
`endif
        case (slot_q)
          2'd0:    sh0_d = bus.din;
          2'd1:    sh1_d = bus.din;
          2'd2:    sh2_d = bus.din;
          default: begin
`ifdef TDM_DEMUX_PARITY_EN
            // A frame with any parity miss is reported, never published.
            if (bad_q || mis) begin
              pe_d = 1'b1;
            end else begin
              y_d  = {bus.din, sh2_q, sh1_q, sh0_q};
              fv_d = 1'b1;
            end
            bad_d = 1'b0;
`else
            y_d  = {bus.din, sh2_q, sh1_q, sh0_q};
            fv_d = 1'b1;
`endif
          end
        endcase
      end
    end
  end

  assign bus.y           = y_q;
  assign bus.frame_valid = fv_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.sync_err    = se_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_err     = pe_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Scoreboard bench for tdm_demux_1x4: directed cases plus random beats.
// Expected pulse events are queued by the driver, popped by a monitor.
// Model holds the current frame as a queue of collected slot values.
module tb_tdm_demux_1x4;
  localparam int W = 1;

  typedef struct {
    int               kind;   // 0 frame, 1 sync_err, 2 par_err
    logic [4*W-1:0]   y;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux_1x4_if #(.WIDTH(W)) bus();
  tdm_demux_1x4 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  ev_t            exp_q[$];
  logic [W-1:0]   fq[$];
  logic           m_locked = 1'b0;
  logic           m_bad = 1'b0;
  logic [4*W-1:0] m_y = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [4*W-1:0] yv);
    ev_t e;
    e.kind = kind;
    e.y = yv;
    exp_q.push_back(e);
  endtask

  // Reference model of one accepted beat, in terms of the frame collected so far.
  task automatic model_beat(input logic s, input logic [W-1:0] d, input logic par_ok);
    if (!m_locked) begin
      if (s) begin
        fq.delete();
        fq.push_back(d);
        m_bad = !par_ok;
        m_locked = 1'b1;
      end
    end else if (s && fq.size() != 0) begin
      push_ev(1, '0);
      fq.delete();
      fq.push_back(d);
      m_bad = !par_ok;
    end else begin
      fq.push_back(d);
      if (!par_ok) m_bad = 1'b1;
      if (fq.size() == 4) begin
        if (m_bad) begin
          push_ev(2, '0);
        end else begin
          for (int k = 0; k < 4; k++) m_y[k*W +: W] = fq[k];
          push_ev(0, m_y);
        end
        fq.delete();
        m_bad = 1'b0;
      end
    end
  endtask

  // Drive one cycle (called just after a rising edge), then check state after the edge.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d, input logic par_flip);
    logic par_ok;
    bus.din_valid = v;
    bus.sync_in = s;
    bus.din = d;
    par_ok = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
    bus.din_par = (^d) ^ par_flip;
    par_ok = !par_flip;
`endif
    if (v) model_beat(s, d, par_ok);
    @(posedge clk);
    #1;
    chk("slot", 32'(bus.slot), 32'(fq.size() % 4));
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("y_hold", 32'(bus.y), 32'(m_y));
  endtask

  task automatic beat(input logic s, input logic [W-1:0] d);
    drive(1'b1, s, d, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_bad = 1'b0;
    m_y = '0;
    fq.delete();
    exp_q.delete();
  endtask

  // Monitor: every pulse seen must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t e;
      if (bus.frame_valid && bus.sync_err) chk("pulse_overlap", 32'd1, 32'd0);
      if (bus.frame_valid) begin
        if (exp_q.size() == 0) chk("unexpected_frame_valid", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("frame_kind", 32'(e.kind), 32'd0);
          chk("frame_y", 32'(bus.y), 32'(e.y));
        end
      end
      if (bus.sync_err) begin
        if (exp_q.size() == 0) chk("unexpected_sync_err", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sync_err_kind", 32'(e.kind), 32'd1);
        end
      end
`ifdef TDM_DEMUX_PARITY_EN
      if (bus.par_err && (bus.frame_valid || bus.sync_err)) chk("par_overlap", 32'd1, 32'd0);
      if (bus.par_err) begin
        if (exp_q.size() == 0) chk("unexpected_par_err", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("par_err_kind", 32'(e.kind), 32'd2);
        end
      end
`endif
    end
  end

  initial begin
    bus.din_valid = 1'b0;
    bus.sync_in = 1'b0;
    bus.din = '0;
`ifdef TDM_DEMUX_PARITY_EN
    bus.din_par = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst_slot", 32'(bus.slot), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_sync_err", 32'(bus.sync_err), 32'd0);
    rst_n = 1'b1;

    // Case 1: 1(sync),0,1,1 -> y=1101.
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1); beat(1'b0, 1'b1);
    chk("t1_y", 32'(bus.y), 32'hD);
    chk("t1_fv", 32'(bus.frame_valid), 32'd1);
    idle();
    chk("t1_fv_one_cycle", 32'(bus.frame_valid), 32'd0);

    // Case 2: reset to HUNT, 3 unsynced beats ignored, then 0,1,0,0 -> y=0010.
    @(negedge clk); rst_n = 1'b0; model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    beat(1'b0, 1'b1); beat(1'b0, 1'b1); beat(1'b0, 1'b1);
    beat(1'b1, 1'b0); beat(1'b0, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
    chk("t2_y", 32'(bus.y), 32'h2);

    // Case 3: same frame with 2-cycle gaps.
    beat(1'b1, 1'b0); idle(); idle();
    beat(1'b0, 1'b1); idle(); idle();
    beat(1'b0, 1'b0); idle(); idle();
    chk("t3_no_early_fv", 32'(bus.frame_valid), 32'd0);
    beat(1'b0, 1'b0);
    chk("t3_y", 32'(bus.y), 32'h2);
    chk("t3_fv", 32'(bus.frame_valid), 32'd1);

    // Case 4: two beats, realigning sync with din=1, then 0,0,1 -> y=1001.
    beat(1'b0, 1'b1); beat(1'b0, 1'b1);
    beat(1'b1, 1'b1);
    chk("t4_sync_err", 32'(bus.sync_err), 32'd1);
    chk("t4_locked", 32'(bus.locked), 32'd1);
    beat(1'b0, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
    chk("t4_y", 32'(bus.y), 32'h9);

    // Case 5: async reset after slot 2, no clock edge before the check.
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_async_y", 32'(bus.y), 32'd0);
    chk("t5_async_slot", 32'(bus.slot), 32'd0);
    chk("t5_async_locked", 32'(bus.locked), 32'd0);
    chk("t5_async_fv", 32'(bus.frame_valid), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    beat(1'b0, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
    chk("t5_still_hunt", 32'(bus.locked), 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
    // Case 6: bad parity on slot 1 suppresses the frame; the next one lands.
    beat(1'b1, 1'b1); beat(1'b0, 1'b1); beat(1'b0, 1'b1); beat(1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_par_err", 32'(bus.par_err), 32'd1);
    chk("t6_y_kept", 32'(bus.y), 32'hF);
    beat(1'b1, 1'b0); beat(1'b0, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
    chk("t6_y_next", 32'(bus.y), 32'hA);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
            W'($urandom), ($urandom_range(0, 9) == 0));
    end
    idle();
    idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
